// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: suspend/redirect control in, instruction ROM port, and the IF/ID presentation.
// master = fetch stage side, slave = pipeline/ROM environment side.
interface if_fetch_stage_if;
  logic        suspend;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        irom_en;
  logic [31:0] irom_addr;
  logic [31:0] irom_rdata;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic        if_misalign;

  modport master (
    input  suspend, redirect, redirect_pc, irom_rdata,
    output irom_en, irom_addr, if_inst, if_pc, if_pc4, if_valid, if_misalign
  );

  modport slave (
    output suspend, redirect, redirect_pc, irom_rdata,
    input  irom_en, irom_addr, if_inst, if_pc, if_pc4, if_valid, if_misalign
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, 1-cycle sync ROM request, 1-entry skid buffer, EX redirects.
// Define IF_MISALIGN_CHK_EN to flag misaligned redirect targets and substitute NOP_INST.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rst_n,
  if_fetch_stage_if.master       bus
);

  logic [31:0] pc_q;
  logic [31:0] resp_pc_q;
  logic        resp_vld_q;
  logic [31:0] skid_inst_q;
  logic [31:0] skid_pc_q;
  logic        skid_vld_q;

  logic        issue;
  logic        skid_load;
  logic        resp_mis;
  logic        skid_mis;

  // Suspend blocks issue, so at most one response is ever in flight and the skid cannot overflow.
  assign issue     = !bus.suspend && !bus.redirect;
  assign skid_load = resp_vld_q && bus.suspend && !skid_vld_q;

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      pc_q        <= RESET_PC;
      resp_pc_q   <= '0;
      resp_vld_q  <= 1'b0;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
      skid_vld_q  <= 1'b0;
    end else if (bus.redirect) begin
      pc_q       <= {bus.redirect_pc[31:2], 2'b00};
      resp_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      if (skid_load) begin
        skid_vld_q  <= 1'b1;
        skid_inst_q <= bus.irom_rdata;
        skid_pc_q   <= resp_pc_q;
      end else if (!bus.suspend) begin
        skid_vld_q <= 1'b0;
      end
      resp_vld_q <= issue;
      if (issue) begin
        resp_pc_q <= pc_q;
        pc_q      <= pc_q + 32'd4;
      end
    end
  end

`ifdef IF_MISALIGN_CHK_EN
  logic mis_pend_q;
  logic resp_mis_q;
  logic skid_mis_q;

  // The flag rides with the first fetch issued after a misaligned redirect.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      mis_pend_q <= 1'b0;
      resp_mis_q <= 1'b0;
      skid_mis_q <= 1'b0;
    end else if (bus.redirect) begin
      mis_pend_q <= |bus.redirect_pc[1:0];
    end else begin
      if (issue) begin
        resp_mis_q <= mis_pend_q;
        mis_pend_q <= 1'b0;
      end
      if (skid_load) begin
        skid_mis_q <= resp_mis_q;
      end
    end
  end

  assign resp_mis = resp_mis_q;
  assign skid_mis = skid_mis_q;
`else
  logic unused_redirect_lo;

  assign unused_redirect_lo = ^bus.redirect_pc[1:0];
  assign resp_mis           = 1'b0;
  assign skid_mis           = 1'b0;
`endif

  logic [31:0] sel_inst;
  logic [31:0] sel_pc;
  logic        sel_vld;
  logic        sel_mis;

  always_comb begin
    sel_inst = '0;
    sel_pc   = '0;
    sel_vld  = 1'b0;
    sel_mis  = 1'b0;
    if (skid_vld_q) begin
      sel_inst = skid_inst_q;
      sel_pc   = skid_pc_q;
      sel_vld  = 1'b1;
      sel_mis  = skid_mis;
    end else if (resp_vld_q) begin
      sel_inst = bus.irom_rdata;
      sel_pc   = resp_pc_q;
      sel_vld  = 1'b1;
      sel_mis  = resp_mis;
    end
  end

  assign bus.irom_en     = issue;
  assign bus.irom_addr   = pc_q;
  assign bus.if_valid    = sel_vld && !bus.redirect;
  assign bus.if_inst     = sel_mis ? NOP_INST : sel_inst;
  assign bus.if_pc       = sel_pc;
  assign bus.if_pc4      = sel_vld ? (sel_pc + 32'd4) : 32'd0;
  assign bus.if_misalign = sel_mis && !bus.redirect;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: per-cycle vector table, consume scoreboard,
// and hand-written reset-mid-stream sequences.
module tb_if_fetch_stage;

`ifdef IF_MISALIGN_CHK_EN
  localparam bit MisOn = 1'b1;
`else
  localparam bit MisOn = 1'b0;
`endif
  localparam logic [31:0] Nop = 32'h0000_0013;

  logic cpu_clk;
  logic cpu_rst_n;
  int   n_tests;
  int   n_fail;
  int   cyc;

  if_fetch_stage_if bus ();

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (Nop)
  ) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst_n (cpu_rst_n),
    .bus       (bus)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  // Sync ROM; returns junk when no read was enabled so stale data cannot masquerade as valid.
  always @(posedge cpu_clk) begin
    cyc <= cyc + 1;
    if (bus.irom_en) bus.irom_rdata <= rom_word(bus.irom_addr);
    else             bus.irom_rdata <= 32'hBAD0_0000 ^ cyc;
  end

  typedef struct {
    logic        s;
    logic        r;
    logic [31:0] rpc;
    logic        ev;
    logic        een;
    logic [31:0] eaddr;
    logic [31:0] epc;
    logic        emis;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb_q[$];

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc, input logic emis,
                              input logic een, input logic [31:0] eaddr);
    vec_t v;
    v.s = s; v.r = r; v.rpc = rpc; v.ev = ev; v.epc = epc; v.emis = emis;
    v.een = een; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_inst;
    n_tests = 0; n_fail = 0; cyc = 0;
    cpu_rst_n = 1'b0;
    bus.suspend = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;

    // s, r, rpc, ev, epc, emis, een, eaddr
    vecs.push_back(mk(0,0,0,            0,0,0,           1,32'h0));    // c0 issue 0
    vecs.push_back(mk(0,0,0,            1,32'h0,0,       1,32'h4));
    vecs.push_back(mk(0,0,0,            1,32'h4,0,       1,32'h8));
    vecs.push_back(mk(0,0,0,            1,32'h8,0,       1,32'hC));
    vecs.push_back(mk(0,0,0,            1,32'hC,0,       1,32'h10));
    vecs.push_back(mk(1,0,0,            1,32'h10,0,      0,0));        // c5 suspend
    vecs.push_back(mk(1,0,0,            1,32'h10,0,      0,0));
    vecs.push_back(mk(1,0,0,            1,32'h10,0,      0,0));
    vecs.push_back(mk(0,0,0,            1,32'h10,0,      1,32'h14));   // skid consume + issue
    vecs.push_back(mk(0,0,0,            1,32'h14,0,      1,32'h18));
    vecs.push_back(mk(0,0,0,            1,32'h18,0,      1,32'h1C));
    vecs.push_back(mk(1,0,0,            1,32'h1C,0,      0,0));        // c11 fill skid
    vecs.push_back(mk(1,0,0,            1,32'h1C,0,      0,0));
    vecs.push_back(mk(1,1,32'h200,      0,0,0,           0,0));        // redirect w/ skid full
    vecs.push_back(mk(1,0,0,            0,0,0,           0,0));
    vecs.push_back(mk(0,0,0,            0,0,0,           1,32'h200));
    vecs.push_back(mk(0,0,0,            1,32'h200,0,     1,32'h204));
    vecs.push_back(mk(0,0,0,            1,32'h204,0,     1,32'h208));
    vecs.push_back(mk(0,1,32'h100,      0,0,0,           0,0));        // c18 back-to-back
    vecs.push_back(mk(0,1,32'h300,      0,0,0,           0,0));
    vecs.push_back(mk(0,0,0,            0,0,0,           1,32'h300));
    vecs.push_back(mk(0,0,0,            1,32'h300,0,     1,32'h304));
    vecs.push_back(mk(0,0,0,            1,32'h304,0,     1,32'h308));
    vecs.push_back(mk(0,1,32'hFFFF_FFFC,0,0,0,           0,0));        // c23 wrap
    vecs.push_back(mk(0,0,0,            0,0,0,           1,32'hFFFF_FFFC));
    vecs.push_back(mk(0,0,0,            1,32'hFFFF_FFFC,0,1,32'h0));
    vecs.push_back(mk(0,0,0,            1,32'h0,0,       1,32'h4));
    vecs.push_back(mk(0,0,0,            1,32'h4,0,       1,32'h8));
    vecs.push_back(mk(0,1,32'h102,      0,0,0,           0,0));        // c28 misaligned
    vecs.push_back(mk(0,0,0,            0,0,0,           1,32'h100));
    vecs.push_back(mk(0,0,0,            1,32'h100,1,     1,32'h104));
    vecs.push_back(mk(0,0,0,            1,32'h104,0,     1,32'h108));
    vecs.push_back(mk(0,1,32'h2,        0,0,0,           0,0));        // c32 misaligned + skid
    vecs.push_back(mk(0,0,0,            0,0,0,           1,32'h0));
    vecs.push_back(mk(1,0,0,            1,32'h0,1,       0,0));
    vecs.push_back(mk(1,0,0,            1,32'h0,1,       0,0));
    vecs.push_back(mk(0,0,0,            1,32'h0,1,       1,32'h4));
    vecs.push_back(mk(0,0,0,            1,32'h4,0,       1,32'h8));
    vecs.push_back(mk(0,1,32'h401,      0,0,0,           0,0));        // c38 later redirect clears
    vecs.push_back(mk(0,1,32'h500,      0,0,0,           0,0));
    vecs.push_back(mk(0,0,0,            0,0,0,           1,32'h500));
    vecs.push_back(mk(0,0,0,            1,32'h500,0,     1,32'h504));

    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk);
    chk("reset if_valid", 32'(bus.if_valid), 0);
    chk("reset if_inst", bus.if_inst, 0);
    chk("reset if_pc", bus.if_pc, 0);
    chk("reset if_pc4", bus.if_pc4, 0);
    chk("reset if_misalign", 32'(bus.if_misalign), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge cpu_clk);
      #1;
      if (i == 0) cpu_rst_n = 1'b1;
      bus.suspend     = vecs[i].s;
      bus.redirect    = vecs[i].r;
      bus.redirect_pc = vecs[i].rpc;
      if (vecs[i].ev && !vecs[i].s && !vecs[i].r) sb_q.push_back(vecs[i].epc);
      @(negedge cpu_clk);
      chk($sformatf("c%0d if_valid", i), 32'(bus.if_valid), 32'(vecs[i].ev));
      chk($sformatf("c%0d irom_en", i), 32'(bus.irom_en), 32'(vecs[i].een));
      if (vecs[i].een) chk($sformatf("c%0d irom_addr", i), bus.irom_addr, vecs[i].eaddr);
      if (vecs[i].ev) begin
        exp_inst = (vecs[i].emis && MisOn) ? Nop : rom_word(vecs[i].epc);
        chk($sformatf("c%0d if_pc", i), bus.if_pc, vecs[i].epc);
        chk($sformatf("c%0d if_pc4", i), bus.if_pc4, vecs[i].epc + 32'd4);
        chk($sformatf("c%0d if_inst", i), bus.if_inst, exp_inst);
        chk($sformatf("c%0d if_misalign", i), 32'(bus.if_misalign),
            32'(vecs[i].emis && MisOn));
      end
      // Consume scoreboard: every consumed PC must be the next one expected.
      if (bus.if_valid && !bus.suspend && !bus.redirect) begin
        if (sb_q.size() == 0) chk($sformatf("c%0d sb unexpected", i), bus.if_pc, 32'hDEAD_BEEF);
        else                  chk($sformatf("c%0d sb consume", i), bus.if_pc, sb_q.pop_front());
      end
    end
    chk("sb leftover", 32'(sb_q.size()), 0);

    // Reset mid-stream.
    @(posedge cpu_clk); #1; cpu_rst_n = 1'b0; bus.suspend = 1'b0; bus.redirect = 1'b0;
    @(posedge cpu_clk); #1;
    @(negedge cpu_clk);
    chk("midrst if_valid", 32'(bus.if_valid), 0);
    chk("midrst if_pc", bus.if_pc, 0);
    chk("midrst if_pc4", bus.if_pc4, 0);
    chk("midrst if_inst", bus.if_inst, 0);
    @(posedge cpu_clk); #1; cpu_rst_n = 1'b1;
    @(negedge cpu_clk);
    chk("rel if_valid", 32'(bus.if_valid), 0);
    chk("rel irom_addr", bus.irom_addr, 0);
    @(posedge cpu_clk); #1; bus.suspend = 1'b1;
    @(negedge cpu_clk);
    chk("rel+1 if_valid", 32'(bus.if_valid), 1);
    chk("rel+1 if_inst", bus.if_inst, rom_word(32'h0));
    // Reset while the skid holds an instruction.
    @(posedge cpu_clk); #1; cpu_rst_n = 1'b0;
    @(negedge cpu_clk);
    chk("skidrst pre if_pc", bus.if_pc, 0);
    chk("skidrst pre if_valid", 32'(bus.if_valid), 1);
    @(posedge cpu_clk); #1; cpu_rst_n = 1'b1; bus.suspend = 1'b0;
    @(negedge cpu_clk);
    chk("skidrst dropped if_valid", 32'(bus.if_valid), 0);
    chk("skidrst irom_addr", bus.irom_addr, 0);
    @(posedge cpu_clk); #1;
    @(negedge cpu_clk);
    chk("skidrst refetch if_valid", 32'(bus.if_valid), 1);
    chk("skidrst refetch if_pc", bus.if_pc, 0);
    chk("skidrst refetch if_inst", bus.if_inst, rom_word(32'h0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
